// File: rtl/mod_counter_param.sv
// Parametrised modulo counter: programmable terminal count, up/down, clear/load,
// and a registered wrap tick for cascading slow enables off the board clock.

// Prefix AND network: o_and[i] = &i_x[i:0], log-depth so the 64-bit step path closes timing.
module mod_counter_param_prefix_and #(
    parameter int W = 31
) (
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_and
);
    localparam int LVL = $clog2(W);

    logic [LVL:0][W-1:0] w_p;

    always_comb begin
        w_p    = '0;
        w_p[0] = i_x;
        for (int k = 0; k < LVL; k++) begin
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << k))
                    w_p[k+1][i] = w_p[k][i] & w_p[k][i-(1<<k)];
                else
                    w_p[k+1][i] = w_p[k][i];
            end
        end
    end

    assign o_and = w_p[LVL];
endmodule

module mod_counter_param #(
    parameter int              WIDTH         = 32,
    parameter longint unsigned DEFAULT_LIMIT = 64'd4999999
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_down,
    input  logic             i_limit_we,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_limit,
    output logic             o_tick
);
    localparam logic [WIDTH-1:0] LIMIT_RST = DEFAULT_LIMIT[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic             r_tick;

    logic [WIDTH-2:0] w_and_ones;
    logic [WIDTH-2:0] w_and_zeros;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_up_wrap;
    logic             w_dn_wrap;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_tick_nxt;

    // Bit i toggles on +1 when all lower bits are ones, on -1 when all lower bits are zeros.
    mod_counter_param_prefix_and #(.W(WIDTH-1)) u_inc_and (
        .i_x   (r_count[WIDTH-2:0]),
        .o_and (w_and_ones)
    );

    mod_counter_param_prefix_and #(.W(WIDTH-1)) u_dec_and (
        .i_x   (~r_count[WIDTH-2:0]),
        .o_and (w_and_zeros)
    );

    assign w_inc = r_count ^ {w_and_ones, 1'b1};
    assign w_dec = r_count ^ {w_and_zeros, 1'b1};

    // Counts above the limit (after a load) wrap on the next step in either direction.
    assign w_up_wrap = (r_count >= r_limit);
    assign w_dn_wrap = (r_count == '0) || (r_count > r_limit);

    always_comb begin
        w_cnt_nxt  = r_count;
        w_tick_nxt = 1'b0;
        if (i_clear) begin
            w_cnt_nxt = '0;
        end else if (i_load) begin
            w_cnt_nxt = i_load_value;
        end else if (i_enable) begin
            if (!i_down) begin
                w_cnt_nxt  = w_up_wrap ? '0 : w_inc;
                w_tick_nxt = w_up_wrap;
            end else begin
                w_cnt_nxt  = w_dn_wrap ? r_limit : w_dec;
                w_tick_nxt = w_dn_wrap;
            end
        end
    end

    // Limit write is independent of the count path; a same-edge step sees the old limit.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_count <= '0;
            r_limit <= LIMIT_RST;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_tick  <= w_tick_nxt;
            if (i_limit_we)
                r_limit <= i_limit;
        end
    end

    assign o_count = r_count;
    assign o_limit = r_limit;
    assign o_tick  = r_tick;
endmodule

// File: tb/tb_mod_counter_param.sv
// Scoreboard bench for mod_counter_param: a narrow instance (WIDTH=8, limit 4) and a default 32-bit one.
module tb_mod_counter_param;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic       a_en = 0, a_clr = 0, a_ld = 0, a_dn = 0, a_lwe = 0;
    logic [7:0] a_ldv = '0, a_lim = '0;
    logic [7:0] a_cnt, a_limo;
    logic       a_tick;

    logic        b_en = 0, b_clr = 0, b_ld = 0, b_dn = 0, b_lwe = 0;
    logic [31:0] b_ldv = '0, b_lim = '0;
    logic [31:0] b_cnt, b_limo;
    logic        b_tick;

    mod_counter_param #(.WIDTH(8), .DEFAULT_LIMIT(64'd4)) dut8 (
        .i_clk(clk), .i_rstn(rstn), .i_enable(a_en), .i_clear(a_clr), .i_load(a_ld),
        .i_load_value(a_ldv), .i_down(a_dn), .i_limit_we(a_lwe), .i_limit(a_lim),
        .o_count(a_cnt), .o_limit(a_limo), .o_tick(a_tick)
    );

    mod_counter_param dut32 (
        .i_clk(clk), .i_rstn(rstn), .i_enable(b_en), .i_clear(b_clr), .i_load(b_ld),
        .i_load_value(b_ldv), .i_down(b_dn), .i_limit_we(b_lwe), .i_limit(b_lim),
        .o_count(b_cnt), .o_limit(b_limo), .o_tick(b_tick)
    );

    typedef struct {
        bit          sel;
        logic [63:0] c;
        logic [63:0] l;
        logic        t;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: every edge that has a pending expectation gets compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (!e.sel) begin
                chk({e.nm, ".count"}, 64'(a_cnt), e.c);
                chk({e.nm, ".limit"}, 64'(a_limo), e.l);
                chk({e.nm, ".tick"}, 64'(a_tick), 64'(e.t));
            end else begin
                chk({e.nm, ".count"}, 64'(b_cnt), e.c);
                chk({e.nm, ".limit"}, 64'(b_limo), e.l);
                chk({e.nm, ".tick"}, 64'(b_tick), 64'(e.t));
            end
        end
    end

    // One 8-bit step issued at a negedge; expectation is what the outputs show after the next posedge.
    task automatic s8(input string nm, input bit en, input bit dn, input bit clr, input bit ld,
                      input int ldv, input bit lwe, input int lim,
                      input int ec, input int el, input bit et);
        exp_t e;
        a_en = en; a_dn = dn; a_clr = clr; a_ld = ld; a_ldv = 8'(ldv); a_lwe = lwe; a_lim = 8'(lim);
        e.sel = 0; e.c = 64'(ec); e.l = 64'(el); e.t = et; e.nm = nm;
        q.push_back(e);
        @(negedge clk);
        a_en = 0; a_dn = 0; a_clr = 0; a_ld = 0; a_lwe = 0;
    endtask

    task automatic s32(input string nm, input bit en, input bit dn, input bit ld,
                       input longint ldv, input longint ec, input bit et);
        exp_t e;
        b_en = en; b_dn = dn; b_ld = ld; b_ldv = 32'(ldv);
        e.sel = 1; e.c = 64'(ec); e.l = 64'd4999999; e.t = et; e.nm = nm;
        q.push_back(e);
        @(negedge clk);
        b_en = 0; b_dn = 0; b_ld = 0;
    endtask

    int up_seq[11]  = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
    int gap_seq[16] = '{1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rstn = 0;
        #2;
        chk("rst8.count", 64'(a_cnt), 64'd0);
        chk("rst8.limit", 64'(a_limo), 64'd4);
        chk("rst8.tick", 64'(a_tick), 64'd0);
        chk("rst32.count", 64'(b_cnt), 64'd0);
        chk("rst32.limit", 64'(b_limo), 64'd4999999);
        @(negedge clk);
        chk("rst8.held", 64'(a_cnt), 64'd0);
        rstn = 1;

        // Continuous up count, period 5 with tick on the return to 0
        for (int i = 0; i < 11; i++)
            s8("up", 1, 0, 0, 0, 0, 0, 0, up_seq[i], 4, up_seq[i] == 0);
        s8("up_to2", 1, 0, 0, 0, 0, 0, 0, 2, 4, 0);

        // Down from 2: 1, 0, 4 (tick), 3
        s8("dn1", 1, 1, 0, 0, 0, 0, 0, 1, 4, 0);
        s8("dn0", 1, 1, 0, 0, 0, 0, 0, 0, 4, 0);
        s8("dnwrap", 1, 1, 0, 0, 0, 0, 0, 4, 4, 1);
        s8("dn3", 1, 1, 0, 0, 0, 0, 0, 3, 4, 0);

        // Limit write with same-edge step uses old limit
        s8("lim_old", 1, 0, 0, 0, 0, 1, 2, 4, 2, 0);
        s8("lim_wrap", 1, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        s8("lim0_wr", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) s8("lim0_up", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) s8("lim0_dn", 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        // Priority and loads above the limit
        s8("lim4_wr", 0, 0, 0, 0, 0, 1, 4, 0, 4, 0);
        s8("ld3", 0, 0, 0, 1, 3, 0, 0, 3, 4, 0);
        s8("clr_pri", 1, 0, 1, 1, 77, 0, 0, 0, 4, 0);
        s8("ld_pri", 1, 0, 0, 1, 2, 0, 0, 2, 4, 0);
        s8("ld200", 0, 0, 0, 1, 200, 0, 0, 200, 4, 0);
        s8("ovr_up", 1, 0, 0, 0, 0, 0, 0, 0, 4, 1);
        s8("ld200b", 0, 0, 0, 1, 200, 0, 0, 200, 4, 0);
        s8("ovr_dn", 1, 1, 0, 0, 0, 0, 0, 4, 4, 1);

        // Enable gaps with L=3: tick every 8 cycles, never on a hold cycle
        s8("lim3_clr", 0, 0, 1, 0, 0, 1, 3, 0, 3, 0);
        for (int i = 0; i < 16; i++)
            s8("gap", (i % 2) == 0, 0, 0, 0, 0, 0, 0, gap_seq[i], 3, (i == 6) || (i == 14));

        // Async reset between edges with C=3, L=9 and a pending limit write
        s8("lim9_clr", 0, 0, 1, 0, 0, 1, 9, 0, 9, 0);
        s8("r_up1", 1, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        s8("r_up2", 1, 0, 0, 0, 0, 0, 0, 2, 9, 0);
        s8("r_up3", 1, 0, 0, 0, 0, 0, 0, 3, 9, 0);
        a_en = 1; a_lwe = 1; a_lim = 8'd9;
        #2 rstn = 0;
        #1;
        chk("arst.count", 64'(a_cnt), 64'd0);
        chk("arst.limit", 64'(a_limo), 64'd4);
        chk("arst.tick", 64'(a_tick), 64'd0);
        @(posedge clk);
        #1;
        chk("arst_hold.count", 64'(a_cnt), 64'd0);
        chk("arst_hold.limit", 64'(a_limo), 64'd4);
        @(negedge clk);
        a_en = 0; a_lwe = 0;
        rstn = 1;
        for (int i = 0; i < 5; i++)
            s8("resume", 1, 0, 0, 0, 0, 0, 0, up_seq[i], 4, up_seq[i] == 0);

        // 32-bit default instance around the 4,999,999 terminal count
        s32("w32_up1", 1, 0, 0, 0, 1, 0);
        s32("w32_up2", 1, 0, 0, 0, 2, 0);
        s32("w32_ld", 0, 0, 1, 4999997, 4999997, 0);
        s32("w32_up", 1, 0, 0, 0, 4999998, 0);
        s32("w32_top", 1, 0, 0, 0, 4999999, 0);
        s32("w32_wrap", 1, 0, 0, 0, 0, 1);
        s32("w32_after", 1, 0, 0, 0, 1, 0);
        s32("w32_dn0", 1, 1, 0, 0, 0, 0);
        s32("w32_dnwrap", 1, 1, 0, 0, 4999999, 1);
        s32("w32_dn", 1, 1, 0, 0, 4999998, 0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mod_counter_param.md
# mod_counter_param

Parametrised modulo counter for timebase generation. It generalises the fixed 32-bit divide-by-5,000,000 counter to any width and adds:
- a runtime-programmable terminal count
- up/down mode
- synchronous clear and parallel load
- a registered wrap tick for cascading

It sits between the system clock and the display/timekeeping logic, producing slow enables such as 10 Hz or 1 Hz from the board clock.

## Interface
- WIDTH, 32, counter and limit width in bits (2..64)
- DEFAULT_LIMIT, 4999999, terminal count loaded into the limit register at reset; must fit in WIDTH bits
- i_clk  input  1  system clock, all state on rising edge
- i_rstn  input  1  reset; asynchronous, active-low
- i_enable  input  1  count-step enable for the current cycle
- i_clear  input  1  synchronous clear of the count
- i_load  input  1  synchronous parallel load of the count
- i_load_value  input  WIDTH  value written by i_load
- i_down  input  1  direction: 0 = up, 1 = down
- i_limit_we  input  1  write strobe for the limit register
- i_limit  input  WIDTH  new terminal count
- o_count  output  WIDTH  current count (register output)
- o_limit  output  WIDTH  current limit register value
- o_tick  output  1  one-cycle registered pulse, high in the cycle after a wrap step

## Operation
- State: count register C (WIDTH bits), limit register L (WIDTH bits), tick register T.
- Count-update priority each edge: i_clear, then i_load, then i_enable step, then hold.
- i_clear: C <= 0, T <= 0.
- i_load: C <= i_load_value, T <= 0. Values greater than L are accepted unchanged.
- Up step (i_enable=1, i_down=0):
  - If C >= L: C <= 0, T <= 1.
  - Else: C <= C+1, T <= 0.
- Down step (i_enable=1, i_down=1):
  - If C == 0 or C > L: C <= L, T <= 1.
  - Else: C <= C-1, T <= 0.
- Hold (i_enable=0, no clear/load): C unchanged, T <= 0.
- Limit register: i_limit_we writes L <= i_limit independently of the count-update priority. The write takes effect from the next cycle; a step on the same edge compares against the old L.
- L = 0: up mode holds C at 0 and pulses T on every enabled cycle; down mode behaves the same.
- Comparisons are unsigned, full WIDTH. Increment and decrement are modulo 2^WIDTH but never overflow, because wrap occurs at L.
- The increment path must meet timing at WIDTH=64. A prefix (AND-tree) toggle network is permitted; a ripple chain is not required to be avoided, but timing closure is mandatory.
- Direction may change on any cycle. The next step uses the new i_down.

## Timing
- Reset (i_rstn low, asynchronous): o_count = 0, o_limit = DEFAULT_LIMIT, o_tick = 0, immediately and held while low.
- Reset release is sampled synchronously. The first possible step is the first rising edge with i_rstn high.
- Latency: all inputs to outputs are 1 cycle. o_tick rises in the same cycle o_count first shows the wrap value (0 up, L down).
- Tick period in continuous up or down counting: exactly L+1 enabled cycles.
- Enable gaps stretch the period; o_tick is never asserted on a non-stepping cycle.
- Mid-operation reset overrides everything, including a pending limit write.
- o_tick is a single-cycle pulse. It is asserted on consecutive cycles only when L = 0 with i_enable held high.

## Test plan
- Reset then up count, WIDTH=8, DEFAULT_LIMIT=4, i_enable=1 -> o_count 0,1,2,3,4,0,1…; o_tick high only when o_count returns to 0, every 5 cycles.
- Down count with L=4: from C=2 -> 1,0,4,3…; o_tick high in the cycle o_count=4 appears.
- Limit change mid-count: C=3, write L=2 with a step on the same edge -> C=4 (old L=4 used); next step wraps to 0 with tick. Then write L=0 -> o_tick high every enabled cycle, o_count stays 0.
- Priority: i_clear=1, i_load=1, i_enable=1 on the same edge -> C=0, o_tick=0. i_load=1 with i_load_value=200 > L -> C=200; next up step -> 0 with tick; next down step instead -> L with tick.
- Enable gaps: toggle i_enable 1/0 with L=3 -> a tick every 8 cycles; o_count holds and o_tick stays low during gaps.
- Asynchronous reset pulse mid-count, between edges, with C=3 and L written to 9 -> o_count=0 and o_limit=DEFAULT_LIMIT immediately; counting resumes from 0 after release. Repeat at WIDTH=32 default: o_tick period is 5,000,000 cycles.
